// File: rtl/font5_base.sv
// FONT5 fast feedback path: bit-flip decode of four ADC channels, gained and
// saturated corrections to two offset-binary DACs, gated by a triggered run window.

module font5_dac_lane #(
  parameter int IN_W  = 22,
  parameter int SHIFT = 4
) (
  input  logic                   clk357,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] i_p,
  input  logic                   i_vld,
  output logic [12:0]            o_dac,
  output logic                   o_clip
);
  localparam logic signed [IN_W-1:0] MAXV = IN_W'(4095);
  localparam logic signed [IN_W-1:0] MINV = IN_W'(-4096);

  logic signed [IN_W-1:0] w_v;
  logic [12:0]            w_sat;

  always_comb begin
    w_v    = i_p >>> SHIFT;
    w_sat  = w_v[12:0];
    o_clip = 1'b0;
    if (w_v > MAXV) begin
      w_sat  = 13'h0FFF;
      o_clip = 1'b1;
    end else if (w_v < MINV) begin
      w_sat  = 13'h1000;
      o_clip = 1'b1;
    end
  end

  // Out-of-window samples park the DAC at midscale.
  always_ff @(posedge clk357 or posedge rst)
    if (rst) o_dac <= 13'h1000;
    else     o_dac <= i_vld ? (w_sat ^ 13'h1000) : 13'h1000;
endmodule

module font5_base #(
  parameter logic [12:0]        CH1_BITFLIP = 13'h0685,
  parameter logic [12:0]        CH2_BITFLIP = 13'h1B88,
  parameter logic [12:0]        CH4_BITFLIP = 13'h1F00,
  parameter logic [12:0]        CH5_BITFLIP = 13'h199A,
  parameter logic signed [7:0]  K1          = 8'sd16,
  parameter logic signed [7:0]  K2          = 8'sd16,
  parameter logic signed [7:0]  K3          = 8'sd16,
  parameter int                 SHIFT       = 4,
  parameter logic [15:0]        WINDOW_LEN  = 16'd280
) (
  input  logic        clk357,
  input  logic        rst,
  input  logic [12:0] ch1_data_in_del,
  input  logic [12:0] ch2_data_in_del,
  input  logic [12:0] ch4_data_in_del,
  input  logic [12:0] ch5_data_in_del,
  input  logic        diginput1,
  output logic [12:0] dac1_out,
  output logic        dac1_clk,
  output logic [12:0] dac2_out,
  output logic        dac2_clk,
  output logic        run,
  output logic        store_strb,
  output logic        led0_out,
  output logic        led1_out,
  output logic        led2_out
);
  localparam int STAGES = 3;
  localparam logic [3:0][12:0] CH_MASK = {CH5_BITFLIP, CH4_BITFLIP, CH2_BITFLIP, CH1_BITFLIP};

  logic              r_s0, r_s1, r_s2;
  logic              r_run, r_led1, r_led2;
  logic [15:0]       r_cnt;
  logic [STAGES-1:0] r_vld_pipe;
  logic [3:0][12:0]  r_c;
  logic [1:0][21:0]  r_p;

  logic              w_edge;
  logic [3:0][12:0]  w_raw;
  logic signed [21:0] w_c1, w_c2, w_c4, w_k1, w_k2, w_k3;
  logic [1:0][12:0]  w_dac;
  logic [1:0]        w_clip;
  logic              w_unused_ch5;

  // r_s0/r_s1 synchronise the trigger; r_s2 holds the previous value for edge detect.
  assign w_edge = r_s1 & ~r_s2;

  always_ff @(posedge clk357 or posedge rst)
    if (rst) begin
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_led2 <= 1'b0;
    end else begin
      r_s0 <= diginput1;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
      if (r_run) begin
        if (r_cnt == '0) r_run <= 1'b0;
        else             r_cnt <= r_cnt - 16'd1;
      end else if (w_edge) begin
        r_run  <= 1'b1;
        r_cnt  <= WINDOW_LEN - 16'd1;
        r_led2 <= ~r_led2;
      end
    end

  assign w_raw = {ch5_data_in_del, ch4_data_in_del, ch2_data_in_del, ch1_data_in_del};
  assign w_c1  = 22'($signed(r_c[0]));
  assign w_c2  = 22'($signed(r_c[1]));
  assign w_c4  = 22'($signed(r_c[2]));
  assign w_k1  = 22'(K1);
  assign w_k2  = 22'(K2);
  assign w_k3  = 22'(K3);
  assign w_unused_ch5 = ^r_c[3];

  // The run flag travels alongside each sample so gating lines up with the data.
  always_ff @(posedge clk357 or posedge rst)
    if (rst) begin
      r_c        <= '0;
      r_p        <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_c        <= w_raw ^ CH_MASK;
      r_p[0]     <= w_c2 * w_k1;
      r_p[1]     <= w_c1 * w_k2 + w_c4 * w_k3;
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], r_run};
    end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    font5_dac_lane #(.IN_W(22), .SHIFT(SHIFT)) u_lane (
      .clk357 (clk357),
      .rst    (rst),
      .i_p    (r_p[i]),
      .i_vld  (r_vld_pipe[1]),
      .o_dac  (w_dac[i]),
      .o_clip (w_clip[i])
    );
  end

  always_ff @(posedge clk357 or posedge rst)
    if (rst) r_led1 <= 1'b0;
    else     r_led1 <= r_led1 | (|w_clip);

  assign dac1_out   = w_dac[0];
  assign dac2_out   = w_dac[1];
  assign dac1_clk   = ~clk357;
  assign dac2_clk   = ~clk357;
  assign run        = r_run;
  assign store_strb = r_vld_pipe[STAGES-1];
  assign led0_out   = r_run;
  assign led1_out   = r_led1;
  assign led2_out   = r_led2;
endmodule

// File: tb/tb_font5_base.sv
// Randomised bench for font5_base: cycle-level behavioural model plus literal spot checks.
module tb_font5_base;
  localparam logic [12:0] M1 = 13'h0685, M2 = 13'h1B88, M4 = 13'h1F00, M5 = 13'h199A;
  localparam int WIN = 280;

  logic clk = 1'b0, rst = 1'b0, din = 1'b0;
  logic [12:0] ch1 = '0, ch2 = '0, ch4 = '0, ch5 = '0;
  logic [12:0] dac1, dac2, b_dac1, unused_b_dac2;
  logic dac1_clk, dac2_clk, run, strb, led0, led1, led2;
  logic unused_b_c1, unused_b_c2, unused_b_run, unused_b_strb, unused_b_l0, b_led1, unused_b_l2;

  int n_checks = 0, n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  font5_base dut (
    .clk357(clk), .rst(rst), .ch1_data_in_del(ch1), .ch2_data_in_del(ch2),
    .ch4_data_in_del(ch4), .ch5_data_in_del(ch5), .diginput1(din),
    .dac1_out(dac1), .dac1_clk(dac1_clk), .dac2_out(dac2), .dac2_clk(dac2_clk),
    .run(run), .store_strb(strb), .led0_out(led0), .led1_out(led1), .led2_out(led2));

  font5_base #(.K1(8'sd32)) dut_k32 (
    .clk357(clk), .rst(rst), .ch1_data_in_del(ch1), .ch2_data_in_del(ch2),
    .ch4_data_in_del(ch4), .ch5_data_in_del(ch5), .diginput1(din),
    .dac1_out(b_dac1), .dac1_clk(unused_b_c1), .dac2_out(unused_b_dac2), .dac2_clk(unused_b_c2),
    .run(unused_b_run), .store_strb(unused_b_strb), .led0_out(unused_b_l0),
    .led1_out(b_led1), .led2_out(unused_b_l2));

  task automatic chk(input string n, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int dec(input logic [12:0] raw, input logic [12:0] m);
    logic signed [12:0] t;
    t = raw ^ m;
    return int'(t);
  endfunction

  function automatic logic [12:0] enc(input int x, input logic [12:0] m);
    logic [12:0] t;
    t = x[12:0];
    return t ^ m;
  endfunction

  function automatic void gain(input int p, output int v, output bit c);
    v = p >>> 4;
    c = 1'b0;
    if (v > 4095)       begin v = 4095;  c = 1'b1; end
    else if (v < -4096) begin v = -4096; c = 1'b1; end
  endfunction

  function automatic logic [12:0] code(input bit w, input int v);
    logic [12:0] t;
    t = v[12:0];
    return w ? (t ^ 13'h1000) : 13'h1000;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { bit win; int v1, v1b, v2; bit c1, c1b, c2; } ent_t;
  ent_t q[$];
  bit   tq[$];
  int   win_left, mc1, mc2, mc4;
  bit   m_led1, m_led1b, m_led2, edge_ok;
  ent_t e;

  function automatic void m_reset();
    ent_t idle;
    idle = '{win: 1'b0, v1: 0, v1b: 0, v2: 0, c1: 1'b0, c1b: 1'b0, c2: 1'b0};
    q = {idle, idle, idle};
    tq = {1'b0, 1'b0, 1'b0};
    win_left = 0;
    m_led1 = 1'b0; m_led1b = 1'b0; m_led2 = 1'b0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) m_reset();
    else begin
      mc1 = dec(ch1, M1); mc2 = dec(ch2, M2); mc4 = dec(ch4, M4);
      e.win = (win_left > 0);
      gain(mc2 * 16, e.v1, e.c1);
      gain(mc2 * 32, e.v1b, e.c1b);
      gain(mc1 * 16 + mc4 * 16, e.v2, e.c2);
      q.push_back(e);
      void'(q.pop_front());
      // tq holds trigger samples taken 3, 2 and 1 edges ago
      edge_ok = tq[1] && !tq[0];
      tq.push_back(din);
      void'(tq.pop_front());
      if (win_left > 0) win_left--;
      else if (edge_ok) begin win_left = WIN; m_led2 = ~m_led2; end
      m_led1  = m_led1  | q[0].c1  | q[0].c2;
      m_led1b = m_led1b | q[0].c1b | q[0].c2;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("dac1",     dac1,     code(q[0].win, q[0].v1));
      chk("dac2",     dac2,     code(q[0].win, q[0].v2));
      chk("k32_dac1", b_dac1,   code(q[0].win, q[0].v1b));
      chk("run",      run,      int'(win_left > 0));
      chk("led0",     led0,     int'(win_left > 0));
      chk("strb",     strb,     q[0].win);
      chk("led1",     led1,     m_led1);
      chk("k32_led1", b_led1,   m_led1b);
      chk("led2",     led2,     m_led2);
      chk("dac1_clk", dac1_clk, 1);
      chk("dac2_clk", dac2_clk, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_run();
    bit got = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (run) got = 1'b1;
    end
    din = 1'b0;
    chk("run_rise", got, 1);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (!run) got = 1'b1;
    end
    chk("run_fall", got, 1);
  endtask

  initial begin
    int n_run, n_strb, first_strb;
    int steps[4];
    logic [12:0] sexp[4];
    steps = '{1024, 512, -512, 0};
    sexp  = '{13'h1400, 13'h1200, 13'h0E00, 13'h1000};
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    ch1 = enc(-256, M1); ch2 = enc(2048, M2); ch4 = enc(500, M4); ch5 = 13'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_dac1", dac1, 13'h1000);
    chk("rst_dac2", dac2, 13'h1000);
    chk("rst_run", run, 0);
    chk("rst_strb", strb, 0);
    chk("rst_leds", {led0, led1, led2}, 0);
    #2 rst = 1'b0;

    // Decode, gain and sum path
    wait_run();
    repeat (2) @(negedge clk);
    chk("strb_early", strb, 0);
    @(negedge clk);
    chk("strb_lat3", strb, 1);
    chk("dac1_2048", dac1, 13'h1800);
    chk("dac2_sum", dac2, 13'h10F4);
    for (int k = 0; k < 4; k++) begin
      ch2 = enc(steps[k], M2);
      repeat (50) @(negedge clk);
      chk("dac1_step", dac1, sexp[k]);
    end
    chk("led1_clean", led1, 0);
    chk("k32_led1_set", b_led1, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("dac1_outwin", dac1, 13'h1000);

    // Window length, retrigger immunity, saturation
    ch2 = enc(2048, M2);
    wait_run();
    n_run = 1; n_strb = 0; first_strb = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 10)  chk("k32_sat_hi", b_dac1, 13'h1FFF);
      if (i == 160) chk("k32_sat_lo", b_dac1, 13'h0000);
      if (i == 100) din = 1'b1;
      if (i == 104) din = 1'b0;
      if (i == 150) ch2 = enc(-4096, M2);
      if (run) n_run++;
      if (strb) begin n_strb++; if (first_strb < 0) first_strb = i; end
    end
    chk("win_len", n_run, WIN);
    chk("strb_len", n_strb, WIN);
    chk("strb_delay", first_strb, 3);

    // Reset mid-window
    wait_run();
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_run", run, 0);
    chk("mrst_strb", strb, 0);
    chk("mrst_dac1", dac1, 13'h1000);
    chk("mrst_dac2", dac2, 13'h1000);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_run();
    n_run = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (run) n_run++;
    end
    chk("post_rst_win", n_run, WIN);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ch1 = 13'($urandom); ch2 = 13'($urandom); ch4 = 13'($urandom); ch5 = 13'($urandom);
      if ($urandom_range(0, 39) == 0) din = ~din;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
